rob_commit_unit: RTL
====================

// Module: rob_commit_unit
// PURPOSE
//   Retire stage on the consuming end of the reorder buffer's head/commit interface.
//   - Watches the ROB head and decides when to pulse commit_en.
//   - Writes retired results to the architectural register file.
//   - Issues committed stores to memory over a valid/ready handshake.
//   - Stops retiring on HALT; only reset clears the halted state.
// PARAMETERS
//   DATA_W   3  width of result/store data
//   REG_W    3  architectural register index width (8 regs, r0 hardwired zero)
//   OP_W     3  opcode width
//   CNT_W    8  retired-instruction counter width
// PORTS
//   clk             in   1       single clock, rising edge
//   rst             in   1       synchronous, active-high reset
//   rob_empty       in   1       ROB holds no entries
//   rob_head_ready  in   1       head entry valid and result complete
//   rob_head_opcode in   OP_W    head opcode
//   rob_head_dest   in   REG_W   head dest reg (store: memory address)
//   rob_head_value  in   DATA_W  head result (store: store data)
//   commit_hold     in   1       debug stall; blocks new retirement decisions
//   commit_en       out  1       ROB pops head at this clock edge
//   rf_we           out  1       architectural regfile write enable
//   rf_waddr        out  REG_W   regfile write index
//   rf_wdata        out  DATA_W  regfile write data
//   st_valid        out  1       store request valid
//   st_addr         out  REG_W   store address
//   st_data         out  DATA_W  store data
//   st_ready        in   1       memory accepts store
//   halted          out  1       HALT retired; no further commits
//   retired_count   out  CNT_W   instructions retired, saturating
// BEHAVIOUR
//   Opcodes: 0 NOP, 1-4 ALU, 5 LOAD, 6 STORE, 7 HALT.
//   Reset (sync, rst=1 at edge):
//     - state=RUN; st_valid/st_addr/st_data=0; halted=0; retired_count=0.
//     - commit_en/rf_we are 0 while rst=1.
//     - Reset mid-store drops st_valid at that edge; the store is not committed.
//   Shared commit condition C = !rob_empty && rob_head_ready && !commit_hold.
//   RUN:
//     - NOP or ALU/LOAD with C: commit_en=1 combinationally, same cycle.
//       ALU/LOAD also drive rf_we=1, rf_waddr=rob_head_dest, rf_wdata=rob_head_value.
//       NOP drives rf_we=0. Throughput is 1 retire/cycle.
//     - dest==0: rf_we=0 but the commit still happens (r0 write suppressed).
//     - STORE with C: commit_en=0. Register st_addr=head_dest, st_data=head_value,
//       st_valid=1 -> STORE_WAIT.
//     - HALT with C: commit_en=1 -> HALTED.
//   STORE_WAIT:
//     - st_valid held high; st_addr/st_data stable until accepted.
//     - commit_hold is ignored while in STORE_WAIT.
//     - st_ready=1: commit_en=1 that cycle (head is still the store); st_valid
//       drops at the edge -> RUN.
//     - Minimum store latency: 2 cycles head-ready -> commit.
//   HALTED:
//     - commit_en, rf_we, st_valid = 0; halted=1 registered.
//     - Leave only by rst.
//   retired_count increments on every commit_en edge, including NOP/HALT/STORE.
//   Saturates at 2^CNT_W-1; no wrap.
//   rob_empty=1 or head not ready: no outputs asserted; state unchanged.
//   commit_en is never asserted when rob_empty=1.
// STRUCTURE
//   cpu_pkg: opcode_e (NOP,ALU0..3,LOAD,STORE,HALT); commit_state_e (RUN,STORE_WAIT,HALTED).
//   cpu_pkg: width localparams shared with the ROB.
//   Single module; no sub-module. FSM plus datapath regs fit comfortably.
// TESTING
//   1 ALU op1 dest=3 val=5, head_ready=1 -> same cycle commit_en=1, rf_we=1, waddr=3,
//     wdata=5; retired_count=1.
//   2 Four back-to-back ready ALU heads -> commit_en high 4 consecutive cycles; count=4.
//   3 STORE dest=2 val=6, st_ready low 3 cycles then high -> st_valid 4 cycles,
//     addr/data stable, single commit_en in the st_ready cycle.
//   4 LOAD dest=0 val=7 -> commit_en=1, rf_we=0.
//   5 HALT followed by ready ALU -> HALT commits, halted=1, ALU never committed.
//   6 rst mid STORE_WAIT -> st_valid=0 next cycle, no commit, count=0, state RUN.
//   Also: count saturation with CNT_W=2; commit_hold blocks a ready head; rob_empty
//   with a stale head_ready=1 -> no commit.

Source files
------------

// File: rtl/rob_commit_unit_pkg.sv
// Shared opcode/state types and widths for the retire stage.
// Widths here are the defaults the ROB is built with.
package rob_commit_unit_pkg;
   localparam int DATA_W = 3;
   localparam int REG_W  = 3;
   localparam int OP_W   = 3;
   localparam int CNT_W  = 8;

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_ALU0  = 3'd1,
      OP_ALU1  = 3'd2,
      OP_ALU2  = 3'd3,
      OP_ALU3  = 3'd4,
      OP_LOAD  = 3'd5,
      OP_STORE = 3'd6,
      OP_HALT  = 3'd7
   } opcode_e;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_STORE_WAIT,
      ST_HALTED
   } commit_state_e;

   function automatic logic writes_rf(opcode_e op);
      return (op inside {OP_ALU0, OP_ALU1, OP_ALU2, OP_ALU3, OP_LOAD});
   endfunction
endpackage

// File: rtl/rob_commit_unit_if.sv
// ROB head, regfile write and store bus seen by the retire stage.
// master is the retire stage, slave is the ROB/regfile/memory side.
interface rob_commit_unit_if #(
   parameter int DATA_W = 3,
   parameter int REG_W  = 3,
   parameter int OP_W   = 3,
   parameter int CNT_W  = 8
);
   logic              rob_empty;
   logic              rob_head_ready;
   logic [OP_W-1:0]   rob_head_opcode;
   logic [REG_W-1:0]  rob_head_dest;
   logic [DATA_W-1:0] rob_head_value;
   logic              commit_hold;
   logic              commit_en;
   logic              rf_we;
   logic [REG_W-1:0]  rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic              st_valid;
   logic [REG_W-1:0]  st_addr;
   logic [DATA_W-1:0] st_data;
   logic              st_ready;
   logic              halted;
   logic [CNT_W-1:0]  retired_count;

   modport master (
      input  rob_empty, rob_head_ready, rob_head_opcode,
      input  rob_head_dest, rob_head_value, commit_hold, st_ready,
      output commit_en, rf_we, rf_waddr, rf_wdata,
      output st_valid, st_addr, st_data, halted, retired_count
   );

   modport slave (
      output rob_empty, rob_head_ready, rob_head_opcode,
      output rob_head_dest, rob_head_value, commit_hold, st_ready,
      input  commit_en, rf_we, rf_waddr, rf_wdata,
      input  st_valid, st_addr, st_data, halted, retired_count
   );
endinterface

// File: rtl/rob_commit_unit.sv
// Retire stage: pops the ROB head, writes the regfile, issues stores.
// Stores retire only once memory accepts them; HALT parks until reset.
module rob_commit_unit
   import rob_commit_unit_pkg::*;
#(
   parameter int DATA_W = rob_commit_unit_pkg::DATA_W,
   parameter int REG_W  = rob_commit_unit_pkg::REG_W,
   parameter int OP_W   = rob_commit_unit_pkg::OP_W,
   parameter int CNT_W  = rob_commit_unit_pkg::CNT_W
) (
   input logic clk,
   input logic rst,
   rob_commit_unit_if.master io
);
   commit_state_e     state;
   opcode_e           op;
   logic              go;
   logic              commit;
   logic              st_valid;
   logic [REG_W-1:0]  st_addr;
   logic [DATA_W-1:0] st_data;
   logic              halted;
   logic [CNT_W-1:0]  count;

   assign op = opcode_e'(io.rob_head_opcode);
   assign go = !io.rob_empty && io.rob_head_ready && !io.commit_hold;

   always_comb begin
      commit = 1'b0;
      unique case (state)
         ST_RUN:        commit = go && (op != OP_STORE);
         // the store is still at the head; hold does not apply here
         ST_STORE_WAIT: commit = io.st_ready && !io.rob_empty;
         default:       commit = 1'b0;
      endcase
      if (rst) commit = 1'b0;
   end

   assign io.commit_en     = commit;
   assign io.rf_we         = commit && (state == ST_RUN) && writes_rf(op)
                             && (io.rob_head_dest != '0);
   assign io.rf_waddr      = io.rob_head_dest;
   assign io.rf_wdata      = io.rob_head_value;
   assign io.st_valid      = st_valid;
   assign io.st_addr       = st_addr;
   assign io.st_data       = st_data;
   assign io.halted        = halted;
   assign io.retired_count = count;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_RUN;
         st_valid <= 1'b0;
         st_addr  <= '0;
         st_data  <= '0;
         halted   <= 1'b0;
         count    <= '0;
      end else begin
         if (commit && (count != '1)) count <= count + 1'b1;
         unique case (state)
            ST_RUN: begin
               if (go && op == OP_STORE) begin
                  st_valid <= 1'b1;
                  st_addr  <= io.rob_head_dest;
                  st_data  <= io.rob_head_value;
                  state    <= ST_STORE_WAIT;
               end else if (go && op == OP_HALT) begin
                  halted <= 1'b1;
                  state  <= ST_HALTED;
               end
            end
            ST_STORE_WAIT: begin
               if (io.st_ready) begin
                  st_valid <= 1'b0;
                  state    <= ST_RUN;
               end
            end
            ST_HALTED: state <= ST_HALTED;
            default:   state <= ST_RUN;
         endcase
      end
   end
endmodule
